// File: rtl/rv32_ifetch_unit.sv
// RV32 instruction fetch: one outstanding word read, 2-entry instruction queue,
// redirect handling with wrong-path response discard.
module rv32_ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pc_sel,
    input  logic [31:0] alu_target,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    // Handshakes: a request transfers on a rising edge where
    // imem_req_valid & imem_req_ready; a response is valid-only (no backpressure).
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_active;
    logic        r_drop;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_q_data [2];
    logic [31:0] r_q_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        w_req_fire;
    logic        w_rsp_take;
    logic        w_push;
    logic        w_pop;
    logic        w_tail;
    logic [31:0] w_target_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (w_req_fire) begin
                w_state_nxt = S_WAIT;
            end
        end else if (imem_rsp_valid) begin
            w_state_nxt = S_IDLE;
        end
    end

    // r_active holds requests off for the first cycle out of reset.
    always_comb begin
        imem_req_valid = r_active && (r_state == S_IDLE) && (r_count != 2'd2) && !pc_sel;
        w_req_fire     = imem_req_valid && imem_req_ready;
        w_rsp_take     = (r_state == S_WAIT) && imem_rsp_valid;
        w_push         = w_rsp_take && !r_drop && !pc_sel;
        w_pop          = inst_valid && !stall && !pc_sel;
    end

    assign w_target_pc = alu_target & 32'hFFFF_FFFC;
    assign w_tail      = r_head ^ r_count[0];
    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = (r_count != 2'd0);
    assign inst        = inst_valid ? r_q_data[r_head] : NOP_INST;
    assign inst_pc     = inst_valid ? r_q_pc[r_head]   : 32'h0000_0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (pc_sel) begin
                r_fetch_pc <= w_target_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_req_fire) begin
                r_req_pc <= r_fetch_pc;
            end
            // A redirect while waiting marks the in-flight response as wrong-path.
            if (w_rsp_take) begin
                r_drop <= 1'b0;
            end else if (pc_sel && (r_state == S_WAIT)) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else if (pc_sel) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; it is only visible while inst_valid=1.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[w_tail] <= imem_rsp_data;
            r_q_pc[w_tail]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_rv32_ifetch_unit.sv
// Directed bench for rv32_ifetch_unit: memory model, request/instruction
// scoreboards, and cycle-level checks around stall, backpressure and redirect.
`timescale 1ns/1ps
module tb_rv32_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        pc_sel = 1'b0;
    logic [31:0] alu_target = 32'h0;
    logic        stall = 1'b0;
    logic        sel = 1'b0;

    logic        v0, v1, iv0, iv1;
    logic [31:0] a0, a1, i0, i1, p0, p1;
    logic        m_rv, m_iv;
    logic [31:0] m_addr, m_inst, m_pc;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int          total = 0;
    int          bad = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] paddr = 32'h0;
    int          hs_cnt = 0;
    logic        chk_rv = 1'b0;

    rv32_ifetch_unit dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(v0), .imem_req_ready(req_ready), .imem_addr(a0),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .pc_sel(pc_sel), .alu_target(alu_target), .stall(stall),
        .inst_valid(iv0), .inst(i0), .inst_pc(p0)
    );

    rv32_ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(v1), .imem_req_ready(req_ready), .imem_addr(a1),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .pc_sel(pc_sel), .alu_target(alu_target), .stall(stall),
        .inst_valid(iv1), .inst(i1), .inst_pc(p1)
    );

    assign m_rv   = sel ? v1  : v0;
    assign m_addr = sel ? a1  : a0;
    assign m_iv   = sel ? iv1 : iv0;
    assign m_inst = sel ? i1  : i0;
    assign m_pc   = sel ? p1  : p0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: responds lat cycles after an accepted request.
    initial forever begin
        @(negedge clk);
        rsp_valid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                rsp_valid = 1'b1;
                rsp_data  = word(paddr);
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    // Monitor: sees the inputs and outputs that apply at the coming rising edge.
    initial begin
        logic [31:0] e;
        logic        waiting;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend      = 1'b0;
                rsp_valid = 1'b0;
            end else begin
                waiting = pend || rsp_valid;
                if (chk_rv) check("req_valid_vs_wait", {31'b0, m_rv}, {31'b0, !waiting});
                if (m_rv && req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got addr %h expected no request", m_addr);
                    end else begin
                        e = exp_addr_q.pop_front();
                        check("req_addr", m_addr, e);
                    end
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = m_addr;
                    hs_cnt++;
                end
                if (m_iv && !stall && !pc_sel) begin
                    if (exp_pc_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_inst: got pc %h expected none", m_pc);
                    end else begin
                        e = exp_pc_q.pop_front();
                        check("inst_pc", m_pc, e);
                        check("inst_data", m_inst, word(e));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_ready = 1'b0; stall = 1'b0; pc_sel = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hs_cnt = 0;
    endtask

    task automatic wait_hs(input int n);
        int k;
        k = 0;
        while (hs_cnt < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (hs_cnt < n) begin
            total++; bad++;
            $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_cnt, n);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d reqs %0d insts left expected 0 0",
                     exp_addr_q.size(), exp_pc_q.size());
        end
    endtask

    initial begin
        #3;
        check("rst_req_valid", {31'b0, m_rv}, 32'h0);
        check("rst_addr", m_addr, 32'h0);
        check("rst_inst_valid", {31'b0, m_iv}, 32'h0);
        check("rst_inst", m_inst, 32'h0000_0013);
        check("rst_inst_pc", m_pc, 32'h0);

        // Free-running fetch, 1-cycle memory.
        do_reset();
        req_ready = 1'b1;
        foreach (exp_addr_q[i]) exp_addr_q.delete(i);
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_pc_q.push_back(32'h0);   exp_pc_q.push_back(32'h4);   exp_pc_q.push_back(32'h8);
        @(negedge clk);
        chk_rv = 1'b1;
        wait_hs(3);
        req_ready = 1'b0;
        wait_drain();
        chk_rv = 1'b0;

        // Stall holds two instructions, no third request.
        do_reset();
        stall = 1'b1; req_ready = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
        repeat (12) @(negedge clk);
        #3;
        check("stall_inst_valid", {31'b0, m_iv}, 32'h1);
        check("stall_head_pc", m_pc, 32'h0);
        check("stall_head_data", m_inst, word(32'h0));
        check("stall_no_req", {31'b0, m_rv}, 32'h0);
        @(negedge clk);
        exp_addr_q.push_back(32'h8);
        exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8);
        stall = 1'b0;
        wait_hs(3);
        req_ready = 1'b0;
        wait_drain();

        // Backpressure: request held stable until accepted.
        do_reset();
        repeat (3) begin
            @(negedge clk);
            #3;
            check("bp_req_valid", {31'b0, m_rv}, 32'h1);
            check("bp_addr", m_addr, 32'h0);
        end
        @(negedge clk);
        exp_addr_q.push_back(32'h0); exp_pc_q.push_back(32'h0);
        req_ready = 1'b1;
        wait_hs(1);
        req_ready = 1'b0;
        #3;
        check("bp_pc_advanced", m_addr, 32'h4);
        wait_drain();

        // Redirect while the 0x8 request waits on a 3-cycle response.
        do_reset();
        req_ready = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_pc_q.push_back(32'h0);   exp_pc_q.push_back(32'h4);
        wait_hs(2);
        lat = 3;
        wait_hs(3);
        req_ready = 1'b0; pc_sel = 1'b1; alu_target = 32'h0000_0102;
        #3;
        check("redir_req_off", {31'b0, m_rv}, 32'h0);
        @(negedge clk);
        pc_sel = 1'b0; req_ready = 1'b1;
        exp_addr_q.push_back(32'h100); exp_pc_q.push_back(32'h100);
        #3;
        check("redir_wait_drop", {31'b0, m_rv}, 32'h0);
        check("redir_target", m_addr, 32'h100);
        @(negedge clk);
        wait_hs(4);
        req_ready = 1'b0;
        wait_drain();

        // Redirect coincident with a response and a pop.
        do_reset();
        stall = 1'b1; req_ready = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
        wait_hs(2);
        pc_sel = 1'b1; stall = 1'b0; alu_target = 32'h0000_0200;
        exp_addr_q.push_back(32'h200); exp_pc_q.push_back(32'h200);
        #3;
        check("coinc_old_valid", {31'b0, m_iv}, 32'h1);
        check("coinc_old_pc", m_pc, 32'h0);
        @(negedge clk);
        pc_sel = 1'b0;
        #3;
        check("coinc_flushed", {31'b0, m_iv}, 32'h0);
        check("coinc_nop", m_inst, 32'h0000_0013);
        check("coinc_pc0", m_pc, 32'h0);
        check("coinc_new_addr", m_addr, 32'h200);
        @(negedge clk);
        wait_hs(3);
        req_ready = 1'b0;
        wait_drain();

        // PC wrap from FFFF_FFF8, then reset in the middle of a wait.
        do_reset();
        sel = 1'b1; req_ready = 1'b1;
        exp_addr_q.push_back(32'hFFFF_FFF8); exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        exp_pc_q.push_back(32'hFFFF_FFF8);   exp_pc_q.push_back(32'hFFFF_FFFC);
        wait_hs(2);
        lat = 3;
        wait_hs(3);
        rst_n = 1'b0; req_ready = 1'b0;
        #3;
        check("midrst_req_valid", {31'b0, m_rv}, 32'h0);
        check("midrst_addr", m_addr, 32'hFFFF_FFF8);
        check("midrst_inst_valid", {31'b0, m_iv}, 32'h0);
        check("midrst_inst", m_inst, 32'h0000_0013);
        check("midrst_inst_pc", m_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32_ifetch_unit.md
Name: rv32_ifetch_unit

Overview:
- Instruction fetch stage of the RV32 pipeline.
- Keeps the fetch PC and issues word reads to instruction memory over a valid/ready request channel with a valid-only response channel.
- Buffers returned words with their PCs in a 2-entry queue and presents them to the decode/control stage as inst/inst_pc/inst_valid.
- Takes pc_sel/target redirects from the control stage and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INST, 32'h0000_0013, value driven on inst when inst_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  request word address, bits[1:0]=0.
- imem_rsp_valid  input  1  read data valid, one cycle per accepted request.
- imem_rsp_data  input  32  read data.
- pc_sel  input  1  redirect: 1 = take alu_target, from control.
- alu_target  input  32  redirect target address.
- stall  input  1  decode cannot consume this cycle.
- inst_valid  output  1  inst/inst_pc hold a valid fetched instruction.
- inst  output  32  instruction to control/decode.
- inst_pc  output  32  PC of inst.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0. Outputs: imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP_INST, inst_pc=0.
- State per request:
  - IDLE: no request outstanding.
  - WAIT: one accepted request awaiting response.
- At most one request outstanding.
- Request issue:
  - imem_req_valid=1 when state=IDLE, (queue count) < 2, and pc_sel=0.
  - imem_addr=fetch_pc.
  - Handshake completes on imem_req_valid & imem_req_ready. Then fetch_pc <= fetch_pc+4 (mod 2^32, wraps FFFF_FFFC -> 0), the request PC is latched, and state -> WAIT.
  - Once asserted, imem_req_valid and imem_addr hold stable until accepted, unless a redirect occurs.
- Response in WAIT:
  - On imem_rsp_valid with drop=0, push {imem_rsp_data, latched PC} into the queue; state -> IDLE.
  - With drop=1, discard the data, clear drop, state -> IDLE.
  - imem_rsp_valid in IDLE is ignored.
  - Minimum round trip is 1 cycle, so back-to-back issue is possible from the cycle after the response.
- Queue:
  - 2 entries, FIFO order.
  - inst_valid = not empty. inst/inst_pc = head entry, else NOP_INST/0.
  - Pop on inst_valid & ~stall.
  - Push and pop in the same cycle are both performed; count unchanged.
  - The issue rule guarantees a push never finds the queue full.
- Redirect (pc_sel=1), highest priority, same cycle:
  - fetch_pc <= {alu_target[31:2],2'b00}.
  - Queue cleared; the pop is ignored.
  - imem_req_valid forced 0.
  - If state=WAIT and no response this cycle, drop <= 1. If a response arrives this cycle, discard it and go to IDLE.
  - inst_valid still reflects the pre-redirect queue during the redirect cycle; it is 0 the next cycle.
  - First request to the target issues the cycle after pc_sel, once the drop response has drained.
- Stall: holds the head; fetching continues until the queue plus outstanding request reach 2.
- Reset mid-operation: all state clears immediately. Instruction memory is reset by the same rst_n, so no stale response is expected. Any response in IDLE is ignored.

Test Plan:
- Reset release, memory always ready with 1-cycle response, stall=0 -> requests to 0x0,0x4,0x8; inst_valid sequence carries inst_pc 0x0,0x4,0x8 with the matching data; imem_req_valid stays high except during WAIT.
- stall=1 for 6 cycles after the first instruction -> queue holds PC 0x0,0x4; no third request issues; after release, 0x0 then 0x4 present in order, then fetch resumes at 0x8.
- imem_req_ready=0 for 3 cycles -> imem_req_valid=1 with imem_addr=0x0 held stable; fetch_pc advances only after acceptance.
- pc_sel=1 with alu_target=0x0000_0102 while a request for 0x8 is in WAIT with a 3-cycle response -> 0x8 data is discarded; next request has imem_addr=0x100; first valid inst_pc after the redirect is 0x100.
- Redirect coincident with a response and a pop -> queue empty next cycle; inst_valid=0 for one cycle; no stale PC ever appears.
- Start fetching with RESET_PC=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; assert rst_n=0 mid-WAIT -> outputs return to reset values immediately.
